// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, bus widths and arbiter FSM encoding.
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_NWORDS = FB_W * FB_H;
  localparam int FB_ADDR_W = 17;
  localparam int FB_PIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_WAIT = 2'd1,
    CLEAR    = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small write FIFO of {addr, data}; head is read straight from the storage flops.
module fb_wr_fifo #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [PIX_W-1:0]  push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [PIX_W-1:0]  head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0]    wr_ptr_r;
  logic [PTR_W:0]    rd_ptr_r;
  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [PIX_W-1:0]  data_mem_r [DEPTH];
  logic              push_ok_s;
  logic              pop_ok_s;

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Wrap bit distinguishes full from empty when the index bits match.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    head_addr = addr_mem_r[rd_ptr_r[PTR_W-1:0]];
    head_data = data_mem_r[rd_ptr_r[PTR_W-1:0]];
  end

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      addr_mem_r[wr_ptr_r[PTR_W-1:0]] <= push_addr;
      data_mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer arbiter: scanout reads > queued raster writes > clear engine.
// One grant per cycle; the grant is registered onto the mem_* bus.
module fb_mem_arbiter #(
  parameter int PIX_W      = fb_pkg::FB_PIX_W,
  parameter int ADDR_W     = fb_pkg::FB_ADDR_W,
  parameter int FB_WORDS   = fb_pkg::FB_NWORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [PIX_W-1:0]  scan_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  fb_state_e         state_r;
  fb_state_e         state_nxt_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [PIX_W-1:0]  head_data_s;
  logic              grant_scan_s;
  logic              grant_fifo_s;
  logic              grant_clr_s;
  logic              clr_last_s;
  logic [ADDR_W-1:0] mem_addr_nxt_s;
  logic [PIX_W-1:0]  mem_wdata_nxt_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [PIX_W-1:0]  clr_color_r;
  logic              scan_pend_r;
  logic              scan_valid_r;

  assign push_s     = wr_valid && wr_ready;
  assign clr_last_s = grant_clr_s && (clr_cnt_r == CLR_LAST);

  fb_wr_fifo #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (grant_fifo_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s)
  );

  // Strict-priority grant and the bus word it will drive next cycle.
  always_comb begin
    grant_scan_s    = 1'b0;
    grant_fifo_s    = 1'b0;
    grant_clr_s     = 1'b0;
    mem_addr_nxt_s  = '0;
    mem_wdata_nxt_s = '0;
    if (scan_req) begin
      grant_scan_s   = 1'b1;
      mem_addr_nxt_s = scan_addr;
    end else if (!fifo_empty_s) begin
      grant_fifo_s    = 1'b1;
      mem_addr_nxt_s  = head_addr_s;
      mem_wdata_nxt_s = head_data_s;
    end else if (state_r == CLEAR) begin
      grant_clr_s     = 1'b1;
      mem_addr_nxt_s  = clr_cnt_r;
      mem_wdata_nxt_s = clr_color_r;
    end else begin
      grant_scan_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next state: CLR_WAIT lets already-queued writes land before the fill starts.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     if (clear_start)  state_nxt_s = CLR_WAIT; else state_nxt_s = IDLE;
      CLR_WAIT: if (fifo_empty_s) state_nxt_s = CLEAR;    else state_nxt_s = CLR_WAIT;
      CLEAR:    if (clr_last_s)   state_nxt_s = IDLE;     else state_nxt_s = CLEAR;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // FSM-derived and pass-through outputs.
  always_comb begin
    clear_busy = (state_r != IDLE);
    wr_ready   = !fifo_full_s && (state_r == IDLE);
    scan_valid = scan_valid_r;
    if (scan_valid_r) scan_data = mem_rdata;
    else              scan_data = '0;
  end

  // Clear colour latch and fill counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_r   <= '0;
      clr_color_r <= '0;
    end else if ((state_r == IDLE) && clear_start) begin
      clr_cnt_r   <= '0;
      clr_color_r <= clear_color;
    end else if (grant_clr_s) begin
      clr_cnt_r <= clr_last_s ? '0 : (clr_cnt_r + ADDR_ONE);
    end else begin
      clr_cnt_r <= clr_cnt_r;
    end
  end

  // Registered RAM bus, scan read delay line and clear completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      scan_pend_r  <= 1'b0;
      scan_valid_r <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      mem_en       <= grant_scan_s | grant_fifo_s | grant_clr_s;
      mem_we       <= grant_fifo_s | grant_clr_s;
      mem_addr     <= mem_addr_nxt_s;
      mem_wdata    <= mem_wdata_nxt_s;
      scan_pend_r  <= grant_scan_s;
      scan_valid_r <= scan_pend_r;
      clear_done   <= clr_last_s;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a 1-cycle-latency RAM model on the mem_* bus.
module tb_fb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        scan_req;
  logic [16:0] scan_addr;
  logic        scan_valid;
  logic [7:0]  scan_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        clear_start;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        tb_we;
  logic [16:0] tb_addr;
  logic [7:0]  tb_data;
  logic [7:0]  ram [0:76799];

  int checks = 0;
  int errors = 0;
  int nw, bad, ready_bad, n, scan_at, cw, seen, wi;
  logic done_seen;
  int exp_en [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int exp_we [10] = '{0, 0, 1, 0, 1, 0, 1, 1, 1, 1};
  int exp_sv [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0};

  fb_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .scan_req    (scan_req),
    .scan_addr   (scan_addr),
    .scan_valid  (scan_valid),
    .scan_data   (scan_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer RAM model with a bench-side preload port.
  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; scan_req = 1'b0; scan_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_start = 1'b0; clear_color = '0;
    tb_we = 1'b1; tb_addr = 17'h00140; tb_data = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    tb_we = 1'b0;

    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_scan_valid", 32'(scan_valid), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    rst = 1'b0;
    step();

    // Scan only: latency 2.
    scan_req = 1'b1; scan_addr = 17'h00140;
    step();
    scan_req = 1'b0;
    chk("scan_t1_en", 32'(mem_en), 32'd1);
    chk("scan_t1_we", 32'(mem_we), 32'd0);
    chk("scan_t1_addr", 32'(mem_addr), 32'h140);
    chk("scan_t1_valid", 32'(scan_valid), 32'd0);
    step();
    chk("scan_t2_valid", 32'(scan_valid), 32'd1);
    chk("scan_t2_data", 32'(scan_data), 32'h5A);
    step();
    chk("scan_t3_valid", 32'(scan_valid), 32'd0);

    // Write then read back.
    wr_valid = 1'b1; wr_addr = 17'h12BFF; wr_data = 8'hE3;
    chk("wr_ready_idle", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    chk("wr_t1_we", 32'(mem_we), 32'd0);
    step();
    chk("wr_t2_we", 32'(mem_we), 32'd1);
    chk("wr_t2_addr", 32'(mem_addr), 32'h12BFF);
    chk("wr_t2_data", 32'(mem_wdata), 32'hE3);
    step();
    scan_req = 1'b1; scan_addr = 17'h12BFF;
    step();
    scan_req = 1'b0;
    step();
    chk("rdback_valid", 32'(scan_valid), 32'd1);
    chk("rdback_data", 32'(scan_data), 32'hE3);
    repeat (2) step();

    // Contention: 10-cycle scan burst while writes queue up.
    for (int c = 0; c < 10; c++) begin
      scan_req = 1'b1; scan_addr = 17'h00140; wr_valid = 1'b1;
      if (c < 4) begin
        wr_addr = 17'(32'h100 + c); wr_data = 8'(32'h10 + c);
      end else begin
        wr_addr = 17'h001FF; wr_data = 8'hFF;
      end
      chk("burst_wr_ready", 32'(wr_ready), (c < 4) ? 32'd1 : 32'd0);
      if (c >= 1) begin
        chk("burst_en", 32'(mem_en), 32'd1);
        chk("burst_we", 32'(mem_we), 32'd0);
      end
      step();
    end
    scan_req = 1'b0; wr_valid = 1'b0;
    chk("burst_tail_we", 32'(mem_we), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'h100 + 32'(k));
      chk("drain_data", 32'(mem_wdata), 32'h10 + 32'(k));
      step();
    end
    chk("drain_idle_en", 32'(mem_en), 32'd0);
    repeat (3) step();

    // Alternating scan with a continuous write stream.
    wi = 0;
    for (int c = 0; c < 10; c++) begin
      scan_req = (c < 6) && (c % 2 == 0); scan_addr = 17'h00140;
      wr_valid = (c < 6); wr_addr = 17'(32'h200 + c); wr_data = 8'(32'h40 + c);
      if (c < 6) chk("alt_wr_ready", 32'(wr_ready), 32'd1);
      chk("alt_en", 32'(mem_en), 32'(exp_en[c]));
      chk("alt_we", 32'(mem_we), 32'(exp_we[c]));
      if (exp_we[c] == 1) begin
        chk("alt_addr", 32'(mem_addr), 32'h200 + 32'(wi));
        chk("alt_data", 32'(mem_wdata), 32'h40 + 32'(wi));
        wi++;
      end
      chk("alt_scan_valid", 32'(scan_valid), 32'(exp_sv[c]));
      chk("alt_scan_data", 32'(scan_data), (exp_sv[c] == 1) ? 32'h5A : 32'h0);
      step();
    end
    scan_req = 1'b0; wr_valid = 1'b0;
    repeat (3) step();

    // Clear behind three pending writes; last write accepted with clear_start.
    for (int a = 0; a < 3; a++) begin
      scan_req = 1'b1; scan_addr = 17'h00140;
      wr_valid = 1'b1; wr_addr = 17'(32'h300 + a); wr_data = 8'(32'h70 + a);
      if (a == 2) begin
        clear_start = 1'b1; clear_color = 8'h00;
        chk("clr_start_ready", 32'(wr_ready), 32'd1);
        chk("clr_start_busy", 32'(clear_busy), 32'd0);
      end
      step();
    end
    scan_req = 1'b0; wr_valid = 1'b0; clear_start = 1'b0;
    chk("clr_wait_busy", 32'(clear_busy), 32'd1);
    chk("clr_wait_ready", 32'(wr_ready), 32'd0);
    nw = 0; bad = 0; ready_bad = 0; n = 0; scan_at = -1; done_seen = 1'b0;
    while (!done_seen && n < 80000) begin
      if (mem_en && mem_we) begin
        if (nw < 3) begin
          if (mem_addr !== 17'(32'h300 + nw) || mem_wdata !== 8'(32'h70 + nw)) bad++;
        end else begin
          if (mem_addr !== 17'(nw - 3) || mem_wdata !== 8'h00) bad++;
        end
        nw++;
      end
      if (clear_done) begin
        done_seen = 1'b1;
        chk("clr_done_count", 32'(nw), 32'd76803);
        chk("clr_done_busy", 32'(clear_busy), 32'd0);
      end else if (wr_ready) begin
        ready_bad++;
      end
      if (scan_at >= 0 && n == scan_at + 1) begin
        chk("mid_scan_en", 32'(mem_en), 32'd1);
        chk("mid_scan_we", 32'(mem_we), 32'd0);
        chk("mid_scan_addr", 32'(mem_addr), 32'h12BFF);
      end
      if (scan_at >= 0 && n == scan_at + 2) begin
        chk("mid_scan_valid", 32'(scan_valid), 32'd1);
        chk("mid_scan_data", 32'(scan_data), 32'hE3);
      end
      if (nw == 1003 && scan_at < 0) begin
        scan_req = 1'b1; scan_addr = 17'h12BFF; scan_at = n;
      end else begin
        scan_req = 1'b0;
      end
      step();
      n++;
    end
    scan_req = 1'b0;
    chk("clr_done_seen", 32'(done_seen), 32'd1);
    chk("clr_seq_bad", 32'(bad), 32'd0);
    chk("clr_ready_low", 32'(ready_bad), 32'd0);
    chk("clr_done_pulse", 32'(clear_done), 32'd0);
    chk("clr_after_ready", 32'(wr_ready), 32'd1);
    scan_req = 1'b1; scan_addr = 17'h00300;
    step();
    scan_addr = 17'h12BFF;
    step();
    scan_req = 1'b0;
    chk("clr_rd_300", 32'(scan_data), 32'h00);
    step();
    chk("clr_rd_12bff", 32'(scan_data), 32'h00);
    repeat (2) step();

    // Reset mid-clear with a scan read in flight.
    clear_start = 1'b1; clear_color = 8'hA5;
    step();
    clear_start = 1'b0;
    cw = 0; n = 0;
    while (cw < 1000 && n < 2000) begin
      if (mem_en && mem_we) cw++;
      if (cw < 1000) step();
      n++;
    end
    chk("mid_clr_count", 32'(cw), 32'd1000);
    scan_req = 1'b1; scan_addr = 17'h00140;
    step();
    scan_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_mem_en", 32'(mem_en), 32'd0);
    chk("mrst_mem_we", 32'(mem_we), 32'd0);
    chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("mrst_scan_valid", 32'(scan_valid), 32'd0);
    chk("mrst_scan_data", 32'(scan_data), 32'd0);
    chk("mrst_clear_done", 32'(clear_done), 32'd0);
    chk("mrst_wr_ready", 32'(wr_ready), 32'd1);
    chk("mrst_clear_busy", 32'(clear_busy), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_scan_valid", 32'(scan_valid), 32'd0);
      chk("post_rst_en", 32'(mem_en), 32'd0);
      step();
    end

    // Restarted clear begins again at address 0.
    clear_start = 1'b1; clear_color = 8'h3C;
    step();
    clear_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_en && mem_we && seen < 3) begin
        chk("restart_addr", 32'(mem_addr), 32'(seen));
        chk("restart_data", 32'(mem_wdata), 32'h3C);
        seen++;
      end
      step();
    end
    chk("restart_writes", 32'(seen), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
